// File: rtl/switch_allocator_rr_if.sv
// Request/grant and crossbar-select bundle between the input buffers,
// the switch allocator and the crossbar outputs.
interface switch_allocator_rr_if #(
  parameter int N_PORTS = 5,
  parameter int SEL_W   = 3
);
  logic [N_PORTS-1:0]       req_valid;
  logic [N_PORTS*SEL_W-1:0] req_port;
  logic [N_PORTS-1:0]       req_tail;
  logic [N_PORTS-1:0]       out_ready;
  logic [N_PORTS-1:0]       grant;
  logic [N_PORTS*SEL_W-1:0] out_sel;
  logic [N_PORTS-1:0]       out_valid;
  logic [N_PORTS-1:0]       out_busy;

  modport master (
    output req_valid, req_port, req_tail, out_ready,
    input  grant, out_sel, out_valid, out_busy
  );

  modport slave (
    input  req_valid, req_port, req_tail, out_ready,
    output grant, out_sel, out_valid, out_busy
  );
endinterface

// File: rtl/switch_allocator_rr.sv
// Packet-locking NoC switch allocator: one round-robin arbiter per output,
// each output held by its winner until that input's tail flit transfers.
module switch_allocator_rr #(
  parameter int N_PORTS     = 5,
  parameter int SEL_W       = 3,
  parameter bit ALLOW_UTURN = 1'b0
) (
  input logic                  clk,
  input logic                  rst,
  switch_allocator_rr_if.slave bus
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_t;

  state_t                   state_r     [N_PORTS];
  state_t                   state_nxt_s [N_PORTS];
  logic [SEL_W-1:0]         owner_r     [N_PORTS];
  logic [SEL_W-1:0]         owner_nxt_s [N_PORTS];
  logic [SEL_W-1:0]         ptr_r       [N_PORTS];
  logic [SEL_W-1:0]         ptr_nxt_s   [N_PORTS];
  logic [SEL_W-1:0]         dest_s      [N_PORTS];
  logic [N_PORTS-1:0]       elig_s      [N_PORTS]; // [output][input]
  logic [N_PORTS-1:0]       owns_s;
  logic [N_PORTS-1:0]       grant_s;
  logic [N_PORTS-1:0]       valid_s;
  logic [N_PORTS-1:0]       busy_s;
  logic [N_PORTS*SEL_W-1:0] sel_s;

  // Eligibility matrix; an input already holding an output may not bid again.
  always_comb begin
    owns_s = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      dest_s[i] = bus.req_port[i*SEL_W +: SEL_W];
    end
    for (int i = 0; i < N_PORTS; i++) begin
      for (int o = 0; o < N_PORTS; o++) begin
        if ((state_r[o] == ST_LOCKED) && (owner_r[o] == SEL_W'(i))) begin
          owns_s[i] = 1'b1;
        end else begin
          owns_s[i] = owns_s[i];
        end
      end
    end
    for (int o = 0; o < N_PORTS; o++) begin
      for (int i = 0; i < N_PORTS; i++) begin
        elig_s[o][i] = bus.req_valid[i] && (dest_s[i] == SEL_W'(o)) &&
                       (ALLOW_UTURN || (i != o)) && !owns_s[i];
      end
    end
  end

  // Per-output next state, round-robin scan and crossbar/grant outputs.
  always_comb begin
    logic             found;
    logic [SEL_W-1:0] win;
    logic             own_valid;
    logic             own_tail;
    logic [SEL_W-1:0] own_dest;
    logic             xfer;
    int               idx;
    found     = 1'b0;
    win       = '0;
    own_valid = 1'b0;
    own_tail  = 1'b0;
    own_dest  = '0;
    xfer      = 1'b0;
    idx       = 0;
    grant_s   = '0;
    valid_s   = '0;
    busy_s    = '0;
    sel_s     = '0;
    for (int o = 0; o < N_PORTS; o++) begin
      state_nxt_s[o]          = state_r[o];
      owner_nxt_s[o]          = owner_r[o];
      ptr_nxt_s[o]            = ptr_r[o];
      sel_s[o*SEL_W +: SEL_W] = SEL_W'(N_PORTS);
      found     = 1'b0;
      win       = '0;
      own_valid = 1'b0;
      own_tail  = 1'b0;
      own_dest  = '0;
      xfer      = 1'b0;
      for (int i = 0; i < N_PORTS; i++) begin
        if (owner_r[o] == SEL_W'(i)) begin
          own_valid = bus.req_valid[i];
          own_tail  = bus.req_tail[i];
          own_dest  = dest_s[i];
        end else begin
          own_valid = own_valid;
        end
      end
      case (state_r[o])
        ST_IDLE: begin
          for (int k = 0; k < N_PORTS; k++) begin
            idx = int'(ptr_r[o]) + k;
            idx = (idx >= N_PORTS) ? (idx - N_PORTS) : idx;
            if (!found && elig_s[o][idx]) begin
              found = 1'b1;
              win   = SEL_W'(idx);
            end else begin
              found = found;
            end
          end
          if (found) begin
            state_nxt_s[o] = ST_LOCKED;
            owner_nxt_s[o] = win;
          end else begin
            state_nxt_s[o] = ST_IDLE;
          end
        end
        ST_LOCKED: begin
          // A stale destination (owner changed port mid-packet) blocks transfer but keeps the lock.
          xfer                    = own_valid && bus.out_ready[o] && (own_dest == SEL_W'(o));
          busy_s[o]               = 1'b1;
          valid_s[o]              = xfer;
          sel_s[o*SEL_W +: SEL_W] = owner_r[o];
          for (int i = 0; i < N_PORTS; i++) begin
            if (owner_r[o] == SEL_W'(i)) begin
              grant_s[i] = grant_s[i] | xfer;
            end else begin
              grant_s[i] = grant_s[i];
            end
          end
          if (xfer && own_tail) begin
            state_nxt_s[o] = ST_IDLE;
            ptr_nxt_s[o]   = (owner_r[o] == SEL_W'(N_PORTS - 1)) ? '0 : (owner_r[o] + SEL_W'(1));
          end else begin
            state_nxt_s[o] = ST_LOCKED;
          end
        end
        default: begin
          state_nxt_s[o] = ST_IDLE;
        end
      endcase
    end
  end

  // Lock state registers; reset drops every lock immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int o = 0; o < N_PORTS; o++) begin
        state_r[o] <= ST_IDLE;
        owner_r[o] <= '0;
        ptr_r[o]   <= '0;
      end
    end else begin
      for (int o = 0; o < N_PORTS; o++) begin
        state_r[o] <= state_nxt_s[o];
        owner_r[o] <= owner_nxt_s[o];
        ptr_r[o]   <= ptr_nxt_s[o];
      end
    end
  end

  assign bus.grant     = grant_s;
  assign bus.out_valid = valid_s;
  assign bus.out_busy  = busy_s;
  assign bus.out_sel   = sel_s;

endmodule

// File: tb/tb_switch_allocator_rr.sv
// Directed-vector bench for switch_allocator_rr: a per-cycle reference model of
// the lock/round-robin rules plus hand-computed checkpoints.
module tb_switch_allocator_rr;
  localparam int N_PORTS = 5;
  localparam int SEL_W   = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   fails   = 0;
  logic [N_PORTS*SEL_W-1:0] none_sel;
  int   order[$];
  int   rr_exp [6] = '{3, 4, 0, 1, 3, 4};
  int   own_m  [N_PORTS] = '{default: -1};
  int   ptr_m  [N_PORTS] = '{default: 0};

  switch_allocator_rr_if #(.N_PORTS(N_PORTS), .SEL_W(SEL_W)) bus ();
  switch_allocator_rr_if #(.N_PORTS(N_PORTS), .SEL_W(SEL_W)) bus_u ();

  switch_allocator_rr #(.N_PORTS(N_PORTS), .SEL_W(SEL_W), .ALLOW_UTURN(1'b0)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave));
  switch_allocator_rr #(.N_PORTS(N_PORTS), .SEL_W(SEL_W), .ALLOW_UTURN(1'b1)) dut_u (
    .clk(clk), .rst(rst), .bus(bus_u.slave));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic drive(input int i, input int port, input bit tail, input bit v);
    bus.req_valid[i]                = v;
    bus.req_port[i*SEL_W +: SEL_W]  = SEL_W'(port);
    bus.req_tail[i]                 = tail;
  endtask

  function automatic int sel(input int o);
    return int'(bus.out_sel[o*SEL_W +: SEL_W]);
  endfunction

  function automatic int port_of(input int i);
    return int'(bus.req_port[i*SEL_W +: SEL_W]);
  endfunction

  // Reference model: owner per output (-1 = free) and next-scan start per output.
  always @(negedge clk) begin : model
    logic [N_PORTS-1:0]       eg, ev, eb;
    logic [N_PORTS*SEL_W-1:0] es;
    int cur  [N_PORTS];
    int cptr [N_PORTS];
    int nown [N_PORTS];
    int nptr [N_PORTS];
    bit held [N_PORTS];
    int w, cand;
    eg = '0; ev = '0; eb = '0; es = '0;
    for (int o = 0; o < N_PORTS; o++) begin
      cur[o]  = rst ? -1 : own_m[o];
      cptr[o] = rst ? 0 : ptr_m[o];
    end
    for (int i = 0; i < N_PORTS; i++) begin
      held[i] = 1'b0;
      for (int o = 0; o < N_PORTS; o++) if (cur[o] == i) held[i] = 1'b1;
    end
    for (int o = 0; o < N_PORTS; o++) begin
      nown[o] = cur[o];
      nptr[o] = cptr[o];
      if (cur[o] >= 0) begin
        w = cur[o];
        eb[o] = 1'b1;
        es[o*SEL_W +: SEL_W] = SEL_W'(w);
        if (bus.req_valid[w] && bus.out_ready[o] && port_of(w) == o) begin
          eg[w] = 1'b1;
          ev[o] = 1'b1;
          if (bus.req_tail[w]) begin
            nown[o] = -1;
            nptr[o] = (w + 1) % N_PORTS;
          end
        end
      end else begin
        es[o*SEL_W +: SEL_W] = SEL_W'(N_PORTS);
        for (int k = 0; k < N_PORTS; k++) begin
          cand = (cptr[o] + k) % N_PORTS;
          if (nown[o] < 0 && bus.req_valid[cand] && port_of(cand) == o &&
              cand != o && !held[cand])
            nown[o] = cand;
        end
      end
    end
    chk("model_grant", int'(bus.grant), int'(eg));
    chk("model_out_valid", int'(bus.out_valid), int'(ev));
    chk("model_out_busy", int'(bus.out_busy), int'(eb));
    chk("model_out_sel", int'(bus.out_sel), int'(es));
    for (int o = 0; o < N_PORTS; o++) begin
      own_m[o] <= rst ? -1 : nown[o];
      ptr_m[o] <= rst ? 0 : nptr[o];
    end
  end

  initial begin
    bus.req_valid   = '0;
    bus.req_port    = '0;
    bus.req_tail    = '0;
    bus.out_ready   = {N_PORTS{1'b1}};
    bus_u.req_valid = '0;
    bus_u.req_port  = '0;
    bus_u.req_tail  = '0;
    bus_u.out_ready = {N_PORTS{1'b1}};
    for (int o = 0; o < N_PORTS; o++) none_sel[o*SEL_W +: SEL_W] = SEL_W'(N_PORTS);

    // Reset and idle
    cyc(); settle();
    chk("rst_busy", int'(bus.out_busy), 0);
    chk("rst_grant", int'(bus.grant), 0);
    chk("rst_valid", int'(bus.out_valid), 0);
    chk("rst_sel", int'(bus.out_sel), 'h5B6D);
    cyc(); rst = 1'b0;
    cyc(); cyc(); settle();
    chk("idle_busy", int'(bus.out_busy), 0);
    chk("idle_sel", int'(bus.out_sel), int'(none_sel));

    // Single-flit packet, input 1 -> output 2
    cyc(); drive(1, 2, 1'b1, 1'b1); settle();
    chk("sf_c0_grant", int'(bus.grant), 0);
    cyc(); settle();
    chk("sf_c1_grant", int'(bus.grant), 5'b00010);
    chk("sf_c1_sel2", sel(2), 1);
    chk("sf_c1_valid", int'(bus.out_valid), 5'b00100);
    cyc(); drive(1, 0, 1'b0, 1'b0); settle();
    chk("sf_c2_busy2", int'(bus.out_busy[2]), 0);
    chk("sf_c2_sel2", sel(2), 5);

    // Lock hold: input 0 sends 3 flits to output 3 while input 4 waits
    cyc(); drive(0, 3, 1'b0, 1'b1); drive(4, 3, 1'b1, 1'b1); settle();
    chk("lk_alloc_grant", int'(bus.grant), 0);
    cyc(); settle();
    chk("lk_f1", int'(bus.grant), 5'b00001);
    cyc(); bus.out_ready[3] = 1'b0; settle();
    chk("lk_stall_grant", int'(bus.grant), 0);
    chk("lk_stall_busy", int'(bus.out_busy), 5'b01000);
    cyc(); bus.out_ready[3] = 1'b1; settle();
    chk("lk_f2", int'(bus.grant), 5'b00001);
    cyc(); drive(0, 3, 1'b1, 1'b1); settle();
    chk("lk_f3", int'(bus.grant), 5'b00001);
    chk("lk_f3_sel", sel(3), 0);
    cyc(); drive(0, 0, 1'b0, 1'b0); settle();
    chk("lk_bubble_busy3", int'(bus.out_busy[3]), 0);
    chk("lk_bubble_grant", int'(bus.grant), 0);
    cyc(); settle();
    chk("lk_in4_grant", int'(bus.grant), 5'b10000);
    chk("lk_in4_sel", sel(3), 4);
    cyc(); drive(4, 0, 1'b0, 1'b0);

    // Round-robin on output 2 (scan starts at 2 after input 1's packet)
    drive(0, 2, 1'b1, 1'b1); drive(1, 2, 1'b1, 1'b1);
    drive(3, 2, 1'b1, 1'b1); drive(4, 2, 1'b1, 1'b1);
    for (int c = 0; c < 12; c++) begin
      settle();
      for (int i = 0; i < N_PORTS; i++) if (bus.grant[i]) order.push_back(i);
      cyc();
    end
    chk("rr_count", order.size(), 6);
    for (int k = 0; k < 6; k++) begin
      if (k < order.size()) chk($sformatf("rr_order_%0d", k), order[k], rr_exp[k]);
      else chk($sformatf("rr_order_%0d", k), -1, rr_exp[k]);
    end

    // U-turn and out-of-range port ignored; U-turn build grants 2 -> 2
    drive(0, 0, 1'b0, 1'b0); drive(1, 0, 1'b0, 1'b0); drive(4, 0, 1'b0, 1'b0);
    drive(2, 2, 1'b1, 1'b1); drive(3, 6, 1'b1, 1'b1);
    bus_u.req_valid[2] = 1'b1;
    bus_u.req_port[2*SEL_W +: SEL_W] = 3'd2;
    bus_u.req_tail[2] = 1'b1;
    settle();
    chk("ut_u_c0_grant", int'(bus_u.grant), 0);
    chk("ut_c0_busy", int'(bus.out_busy), 0);
    cyc(); settle();
    chk("ut_u_c1_grant", int'(bus_u.grant), 5'b00100);
    chk("ut_u_c1_sel2", int'(bus_u.out_sel[2*SEL_W +: SEL_W]), 2);
    chk("ut_c1_grant", int'(bus.grant), 0);
    cyc(); bus_u.req_valid = '0; settle();
    chk("ut_c2_busy", int'(bus.out_busy), 0);
    cyc(); drive(2, 0, 1'b0, 1'b0); drive(3, 0, 1'b0, 1'b0);

    // Owner changes destination mid-packet: no grant, lock held
    drive(0, 1, 1'b0, 1'b1); settle();
    cyc(); settle();
    chk("pe_f1", int'(bus.grant), 5'b00001);
    cyc(); drive(0, 4, 1'b0, 1'b1); settle();
    chk("pe_grant", int'(bus.grant), 0);
    chk("pe_busy", int'(bus.out_busy), 5'b00010);
    cyc(); settle();
    chk("pe_hold", int'(bus.out_busy), 5'b00010);
    cyc(); drive(0, 1, 1'b1, 1'b1); settle();
    chk("pe_tail", int'(bus.grant), 5'b00001);
    cyc(); drive(0, 0, 1'b0, 1'b0);

    // Move output 3's pointer to 2, then reset in the middle of a packet
    drive(1, 3, 1'b1, 1'b1); settle();
    cyc(); settle();
    chk("ar_pre_grant", int'(bus.grant), 5'b00010);
    cyc(); drive(1, 0, 1'b0, 1'b0); drive(0, 3, 1'b0, 1'b1); settle();
    cyc(); settle();
    chk("ar_f1", int'(bus.grant), 5'b00001);
    cyc(); settle();
    chk("ar_f2", int'(bus.grant), 5'b00001);
    cyc(); rst = 1'b1; #1;
    chk("ar_busy", int'(bus.out_busy), 0);
    chk("ar_sel", int'(bus.out_sel), int'(none_sel));
    chk("ar_grant", int'(bus.grant), 0);
    cyc(); rst = 1'b0;
    drive(0, 0, 1'b0, 1'b0); drive(1, 3, 1'b1, 1'b1); drive(2, 3, 1'b1, 1'b1); settle();
    chk("ar_alloc_grant", int'(bus.grant), 0);
    cyc(); settle();
    chk("ar_ptr0_grant", int'(bus.grant), 5'b00010);
    chk("ar_ptr0_sel3", sel(3), 1);
    cyc(); drive(1, 0, 1'b0, 1'b0);
    cyc(); cyc(); drive(2, 0, 1'b0, 1'b0);
    cyc(); cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule

// File: doc/switch_allocator_rr.md
# switch_allocator_rr

Parametrised, packet-locking switch allocator for the NoC router. It arbitrates among N_PORTS input buffers competing for N_PORTS crossbar outputs. Each output has its own round-robin pointer, and an output stays locked to its winning input until that input's tail flit has transferred. The block drives the crossbar select lines and returns a per-input grant to the input buffers.

## Interface
**Parameters**
- N_PORTS, 5, number of router ports (L, N, E, S, W in the 5-port build); index 0 = LOCAL.
- SEL_W, 3, width of a port index; must satisfy 2^SEL_W > N_PORTS.
- ALLOW_UTURN, 0, 1 = input i may be granted output i; 0 = such requests are ignored.

**Ports**
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  N_PORTS  input i holds a flit.
- req_port  in  N_PORTS*SEL_W  destination output of input i, slice [i*SEL_W +: SEL_W].
- req_tail  in  N_PORTS  the flit at input i is the last of its packet (single-flit packet: head = tail).
- out_ready  in  N_PORTS  downstream of output o can accept a flit this cycle.
- grant  out  N_PORTS  input i's flit transfers this cycle; the buffer pops on grant.
- out_sel  out  N_PORTS*SEL_W  index of the input driving output o; value N_PORTS = none.
- out_valid  out  N_PORTS  a flit is on output o this cycle.
- out_busy  out  N_PORTS  output o is locked to an owner.

## Operation
**Per-output state:** locked (1 bit), owner (SEL_W bits), ptr (SEL_W bits).

**Eligible request** of input i for output o, all of the following:
- req_valid[i] = 1;
- req_port[i] = o, and o < N_PORTS (out-of-range port values are ignored);
- i ≠ o, or ALLOW_UTURN = 1;
- input i is not currently the owner of any locked output.

**IDLE (locked = 0)**
- Scan inputs ptr, ptr+1, …, wrapping modulo N_PORTS.
- The first eligible input wins: at the next edge, locked ← 1 and owner ← winner.
- No grant is issued in the allocation cycle.
- If two idle outputs would both pick the same input, that cannot happen: an input requests only one port.

**LOCKED**
- out_sel[o] = owner.
- Transfer on output o = req_valid[owner] & out_ready[o] & (req_port[owner] = o).
- grant[owner] = out_valid[o] = transfer.
- When transfer & req_tail[owner]: at the next edge, locked ← 0 and ptr ← (owner+1) mod N_PORTS.
- A non-tail transfer keeps the lock.
- req_valid low or out_ready low while locked: no transfer, lock held indefinitely.

**Other rules**
- Each input owns at most one output, so grant is at most one-hot per input and each output has at most one transfer per cycle.
- The owner changing req_port while locked is a protocol error. Required response: no grant for the owner on the locked output; the lock is still held.
- **Reset values:** locked = 0, ptr = 0, owner = 0; out_sel = N_PORTS on every output; grant = 0, out_valid = 0, out_busy = 0.
- **Reset mid-packet:** the lock is dropped immediately (asynchronous), and outputs go to their reset values in the same cycle.

## Timing
- grant, out_valid and out_sel are combinational from the registered lock state plus current inputs. There is no combinational path from req_* to out_sel.
- **Allocation latency:** a request first eligible in cycle t receives its first grant in cycle t+1 at the earliest, subject to out_ready.
- **Release:** tail transfer in cycle k puts the output in IDLE in cycle k+1; the next owner's first grant comes in cycle k+2. This one-cycle bubble per packet is by design.
- **N-flit packet with out_ready held high:** occupies the output for N+1 cycles including allocation.
- **Fairness:** with all inputs requesting continuously, each eligible input wins within N_PORTS-1 packets.
- Simultaneous tail transfer on output o and a new request for o from another input: the new request is not allocated before cycle k+1. It is arbitrated with the updated ptr.

## Test plan
- **Reset / idle:** assert rst → out_sel = 5 on all outputs; grant, out_valid, out_busy = 0. Deassert rst, no requests → state unchanged.
- **Single-flit packet:** input 1 (N) requests output 2 (E) with tail = 1 at cycle 0, out_ready = 1.
  - Cycle 1: grant[1] = 1, out_sel[2] = 1, out_valid[2] = 1.
  - Cycle 2: out_busy[2] = 0, out_sel[2] = 5.
- **Lock hold:** 3-flit packet from input 0 to output 3; input 4 also requests output 3.
  - Input 0 is granted for 3 transfers; input 4 gets nothing until then.
  - Input 4 is allocated the cycle after the tail and granted the following cycle.
  - out_ready deasserted mid-packet stalls grant without releasing the lock.
- **Round-robin:** inputs 0, 1, 3, 4 each send repeated single-flit packets to output 2 → grant order 0, 1, 3, 4, 0 …; no input is granted twice before all others.
- **U-turn / range:** ALLOW_UTURN = 0 and input 2 requests output 2 → never granted, out_busy[2] = 0. req_port = 6 → ignored. With ALLOW_UTURN = 1, input 2 → output 2 is granted in cycle 1.
- **Async reset mid-packet:** assert rst between flit 2 and flit 3 of a locked packet.
  - Same cycle: out_busy = 0 and out_sel = 5.
  - After release, a fresh request is arbitrated from ptr = 0.
